// File: rtl/auth_arb_pkg.sv
// Shared state encoding and default sizing for the keypad authentication arbiter.
package auth_arb_pkg;

  localparam int unsigned N_REQ_DEF          = 4;
  localparam int unsigned MAX_FAILS_DEF      = 3;
  localparam int unsigned LOCK_CYCLES_DEF    = 1000;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
  localparam int unsigned PW_W               = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REPORT
  } arb_state_e;

endpackage

// File: rtl/auth_lock_timer.sv
// Per-requester consecutive-failure counter and lockout timer.
module auth_lock_timer
  import auth_arb_pkg::*;
#(
  parameter int unsigned MAX_FAILS   = MAX_FAILS_DEF,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic report_i,
  input  logic pass_i,
  output logic locked_o
);

  localparam int unsigned CW = $clog2(MAX_FAILS + 1);
  localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          lock_q, lock_d;

  assign locked_o = lock_q;

  always_comb begin
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    lock_d  = lock_q;
    cnt_inc = (cnt_q == CW'(MAX_FAILS)) ? cnt_q : cnt_q + 1'b1;
    if (lock_q) begin
      // Timer value 1 is the last locked cycle; history is wiped on release.
      if (tmr_q == TW'(1)) begin
        lock_d = 1'b0;
        cnt_d  = '0;
        tmr_d  = '0;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end else if (report_i) begin
      if (pass_i) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(MAX_FAILS)) begin
          lock_d = 1'b1;
          tmr_d  = TW'(LOCK_CYCLES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tmr_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/auth_request_arbiter.sv
// Round-robin arbiter sharing one password authenticator among N_REQ keypads,
// with per-keypad failure lockout and an authenticator response timeout.
module auth_request_arbiter
  import auth_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = N_REQ_DEF,
  parameter int unsigned MAX_FAILS      = MAX_FAILS_DEF,
  parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [PW_W*N_REQ-1:0] pw_in,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      pass,
  output logic [N_REQ-1:0]      locked,
  output logic                  auth_valid,
  output logic [PW_W-1:0]       auth_password,
  input  logic                  auth_ready,
  input  logic                  auth_done,
  input  logic                  auth_match
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_e                 state_q, state_d;
  logic [IW-1:0]              gnt_q, gnt_d, last_q, last_d, sel, cand;
  logic                       sel_vld;
  logic [PW_W-1:0]            pw_q, pw_d;
  logic [TW-1:0]              tmo_q, tmo_d;
  logic                       res_q, res_d;
  logic [N_REQ-1:0]           elig;
  logic [N_REQ-1:0][PW_W-1:0] pw_arr;

  assign pw_arr        = pw_in;
  assign elig          = req & ~locked;
  assign auth_password = pw_q;

  // Search starts one past the last served requester so everyone gets a turn.
  always_comb begin
    sel     = last_q;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (!sel_vld && elig[cand]) begin
        sel_vld = 1'b1;
        sel     = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    pw_d       = pw_q;
    tmo_d      = tmo_q;
    res_d      = res_q;
    auth_valid = 1'b0;
    done       = '0;
    pass       = '0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d   = sel;
          pw_d    = pw_arr[sel];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        auth_valid = 1'b1;
        if (auth_ready) begin
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (auth_done) begin
          res_d   = auth_match;
          state_d = REPORT;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = 1'b0;
          state_d = REPORT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REPORT: begin
        done[gnt_q] = 1'b1;
        pass[gnt_q] = res_q;
        last_d      = gnt_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      pw_q    <= '0;
      tmo_q   <= '0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      pw_q    <= pw_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lock
    auth_lock_timer #(
      .MAX_FAILS  (MAX_FAILS),
      .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock (
      .clk      (clk),
      .rst_n    (rst_n),
      .report_i (done[i]),
      .pass_i   (pass[i]),
      .locked_o (locked[i])
    );
  end

endmodule

// File: tb/tb_auth_request_arbiter.sv
// Directed bench for auth_request_arbiter; inputs driven and outputs sampled on falling edges.
module tb_auth_request_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] pw_in;
  logic [3:0]  done, pass, locked;
  logic        auth_valid;
  logic [15:0] auth_password;
  logic        auth_ready = 1'b1;
  logic        auth_done = 1'b0;
  logic        auth_match = 1'b0;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] PW_DEF = {16'h4444, 16'h3333, 16'h2222, 16'h1234};

  always #5 clk = ~clk;

  auth_request_arbiter #(
    .N_REQ(4), .MAX_FAILS(3), .LOCK_CYCLES(1000), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .pw_in         (pw_in),
    .done          (done),
    .pass          (pass),
    .locked        (locked),
    .auth_valid    (auth_valid),
    .auth_password (auth_password),
    .auth_ready    (auth_ready),
    .auth_done     (auth_done),
    .auth_match    (auth_match)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; auth_done = 1'b0; auth_match = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays the authenticator for one transaction; dly<0 means never answer.
  task automatic serve(input bit match, input int dly,
                       output logic [3:0] dv, output logic [3:0] pv, output logic [15:0] pw);
    int n;
    n = 0; dv = '0; pv = '0; pw = '0;
    while (!auth_valid && n < 50) begin @(negedge clk); n++; end
    pw = auth_password;
    if (dly >= 0) begin
      repeat (dly + 1) @(negedge clk);
      auth_done = 1'b1; auth_match = match;
    end
    n = 0;
    do begin
      @(negedge clk);
      auth_done = 1'b0; auth_match = 1'b0; n++;
    end while (done == '0 && n < 100);
    dv = done; pv = pass;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; pw_in = PW_DEF;
    repeat (2) @(negedge clk);
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
    checks++; if (pass !== 4'b0) begin errors++; $display("FAIL reset_pass: got %b want 0000", pass); end
    checks++; if (locked !== 4'b0) begin errors++; $display("FAIL reset_locked: got %b want 0000", locked); end
    checks++; if (auth_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", auth_valid); end
    checks++; if (auth_password !== 16'h0) begin errors++; $display("FAIL reset_pw: got %h want 0000", auth_password); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    @(negedge clk);
    checks++; if (auth_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", auth_valid); end
    checks++; if (auth_password !== 16'h1234) begin errors++; $display("FAIL single_pw: got %h want 1234", auth_password); end
    pw_in[15:0] = 16'hBEEF;
    @(negedge clk);
    checks++; if (auth_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", auth_valid); end
    checks++; if (auth_password !== 16'h1234) begin errors++; $display("FAIL single_pw_hold: got %h want 1234", auth_password); end
    req = 4'b0000; auth_done = 1'b1; auth_match = 1'b1;
    @(negedge clk);
    auth_done = 1'b0; auth_match = 1'b0;
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", done); end
    checks++; if (pass !== 4'b0001) begin errors++; $display("FAIL single_pass: got %b want 0001", pass); end
    @(negedge clk);
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b want 0000", done); end
    pw_in = PW_DEF;
  endtask

  task automatic test_round_robin();
    int          ord [5] = '{0, 1, 2, 3, 0};
    logic [15:0] pwv [4] = '{16'h1234, 16'h2222, 16'h3333, 16'h4444};
    logic [3:0]  dv, pv, exp;
    logic [15:0] pw;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(1'b1, 0, dv, pv, pw);
      exp = 4'b0001 << ord[i];
      checks++; if (dv !== exp) begin errors++; $display("FAIL rr_done[%0d]: got %b want %b", i, dv, exp); end
      checks++; if (pv !== exp) begin errors++; $display("FAIL rr_pass[%0d]: got %b want %b", i, pv, exp); end
      checks++; if (pw !== pwv[ord[i]]) begin errors++; $display("FAIL rr_pw[%0d]: got %h want %h", i, pw, pwv[ord[i]]); end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_lockout();
    logic [3:0]  dv, pv;
    logic [15:0] pw;
    int bad;
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      serve(1'b0, 0, dv, pv, pw);
      checks++; if (dv !== 4'b0010 || pv !== 4'b0000) begin errors++; $display("FAIL lock_fail[%0d]: got done=%b pass=%b want 0010/0000", i, dv, pv); end
    end
    checks++; if (locked !== 4'b0000) begin errors++; $display("FAIL lock_early: got %b want 0000", locked); end
    @(negedge clk);
    checks++; if (locked !== 4'b0010) begin errors++; $display("FAIL lock_rise: got %b want 0010", locked); end
    bad = 0;
    for (int i = 2; i <= 1000; i++) begin
      @(negedge clk);
      if (locked !== 4'b0010 || auth_valid !== 1'b0 || done !== 4'b0000) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lock_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk);
    checks++; if (locked !== 4'b0000) begin errors++; $display("FAIL lock_release: got %b want 0000", locked); end
    // A cleared count means two new fails must not relock.
    for (int i = 0; i < 2; i++) begin
      serve(1'b0, 0, dv, pv, pw);
      checks++; if (dv !== 4'b0010) begin errors++; $display("FAIL unlock_serve[%0d]: got %b want 0010", i, dv); end
    end
    @(negedge clk);
    checks++; if (locked !== 4'b0000) begin errors++; $display("FAIL unlock_count: got %b want 0000", locked); end
    serve(1'b1, 0, dv, pv, pw);
    checks++; if (pv !== 4'b0010) begin errors++; $display("FAIL unlock_pass: got %b want 0010", pv); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [3:0]  dv, pv;
    logic [15:0] pw;
    int n;
    req = 4'b1000;
    n = 0;
    while (!auth_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (auth_valid !== 1'b1) begin errors++; $display("FAIL tmo_issue: got %b want 1", auth_valid); end
    // Strobe during ISSUE must be ignored.
    auth_done = 1'b1; auth_match = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      auth_done = 1'b0; auth_match = 1'b0; n++;
    end while (done == '0 && n < 100);
    checks++; if (n !== 65) begin errors++; $display("FAIL tmo_latency: got %0d want 65", n); end
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL tmo_done: got %b want 1000", done); end
    checks++; if (pass !== 4'b0000) begin errors++; $display("FAIL tmo_pass: got %b want 0000", pass); end
    for (int i = 0; i < 2; i++) serve(1'b0, 0, dv, pv, pw);
    @(negedge clk);
    checks++; if (locked !== 4'b1000) begin errors++; $display("FAIL tmo_counts_fail: got %b want 1000", locked); end
    do_reset();
  endtask

  task automatic test_pass_clears();
    logic [3:0]  dv, pv;
    logic [15:0] pw;
    req = 4'b0100;
    for (int i = 0; i < 2; i++) serve(1'b0, 0, dv, pv, pw);
    serve(1'b1, 0, dv, pv, pw);
    checks++; if (pv !== 4'b0100) begin errors++; $display("FAIL clr_pass: got %b want 0100", pv); end
    for (int i = 0; i < 2; i++) serve(1'b0, 0, dv, pv, pw);
    @(negedge clk);
    checks++; if (locked !== 4'b0000) begin errors++; $display("FAIL clr_two_fails: got %b want 0000", locked); end
    serve(1'b0, 0, dv, pv, pw);
    checks++; if (dv !== 4'b0100) begin errors++; $display("FAIL clr_third_done: got %b want 0100", dv); end
    @(negedge clk);
    checks++; if (locked !== 4'b0100) begin errors++; $display("FAIL clr_third_lock: got %b want 0100", locked); end
    req = '0;
  endtask

  task automatic test_reset_wait();
    logic [3:0]  dv, pv;
    logic [15:0] pw;
    int n;
    req = 4'b0001;
    n = 0;
    while (!auth_valid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (done !== 4'b0 || pass !== 4'b0) begin errors++; $display("FAIL rstw_done: got done=%b pass=%b want 0000/0000", done, pass); end
    checks++; if (auth_valid !== 1'b0) begin errors++; $display("FAIL rstw_valid: got %b want 0", auth_valid); end
    checks++; if (auth_password !== 16'h0) begin errors++; $display("FAIL rstw_pw: got %h want 0000", auth_password); end
    checks++; if (locked !== 4'b0) begin errors++; $display("FAIL rstw_locked: got %b want 0000", locked); end
    rst_n = 1'b1;
    serve(1'b1, 0, dv, pv, pw);
    checks++; if (dv !== 4'b0001 || pv !== 4'b0001) begin errors++; $display("FAIL rstw_serve: got done=%b pass=%b want 0001/0001", dv, pv); end
    checks++; if (pw !== 16'h1234) begin errors++; $display("FAIL rstw_pw_after: got %h want 1234", pw); end
    req = '0;
  endtask

  initial begin
    pw_in = PW_DEF;
    test_reset();
    test_single();
    test_round_robin();
    test_lockout();
    test_timeout();
    test_pass_clears();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
